// File: rtl/mips_pkg.sv
// Shared forwarding types: mux select codes, register-address width, pipeline slot record.
// No logic or latency of its own.
// No flow control of its own.
package mips_pkg;

    localparam int NB_REG_ADDR = 5;

    localparam logic [1:0] FWD_SEL_REG = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    typedef struct packed {
        logic                   valid;
        logic [NB_REG_ADDR-1:0] dst;
        logic                   reg_write;
        logic                   mem_read;
    } fwd_slot_t;

    // A write to $zero is architecturally discarded, so it never matches.
    function automatic logic slot_matches(input fwd_slot_t slot,
                                          input logic [NB_REG_ADDR-1:0] r);
        return slot.valid & slot.reg_write & (slot.dst == r) & (r != '0);
    endfunction

endpackage

// File: rtl/fwd_slot_reg.sv
// One pipeline-stage shadow of the destination-register info.
// Latency: one cycle.
// Backpressure: enable_i = 0 holds the slot; bubble_i loads an invalid entry.
module fwd_slot_reg
    import mips_pkg::*;
(
    input  logic      clock_i,
    input  logic      reset_n_i,
    input  logic      enable_i,
    input  logic      bubble_i,
    input  fwd_slot_t slot_i,
    output fwd_slot_t slot_o
);

    fwd_slot_t slot_d;
    fwd_slot_t slot_q;

    always_comb begin
        slot_d = slot_q;
        if (enable_i) begin
            slot_d = bubble_i ? fwd_slot_t'('0) : slot_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects and load-use stall request for the 5-stage core.
// Latency: selects are registered as the consumer enters EX; stall_o is combinational.
// Backpressure: enable_i = 0 freezes all state; stall_o holds IF/ID and bubbles EX.
module forwarding_unit #(
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic                   id_valid_i,
    input  logic [NB_REG_ADDR-1:0] id_rs_i,
    input  logic [NB_REG_ADDR-1:0] id_rt_i,
    input  logic [NB_REG_ADDR-1:0] id_dst_i,
    input  logic                   id_reg_write_i,
    input  logic                   id_mem_read_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [1:0]             fwd_a_sel_o,
    output logic [1:0]             fwd_b_sel_o
);

    import mips_pkg::*;

    fwd_slot_t  id_slot;
    fwd_slot_t  ex_q;
    fwd_slot_t  mem_q;
    fwd_slot_t  wb_q;
    logic       hazard;
    logic       ex_bubble;
    logic [1:0] fwd_a_sel_d;
    logic [1:0] fwd_a_sel_q;
    logic [1:0] fwd_b_sel_d;
    logic [1:0] fwd_b_sel_q;

    // Evaluated against the slots before they advance: EX now is MEM next cycle.
    function automatic logic [1:0] sel_for(input logic [NB_REG_ADDR-1:0] r);
        if (slot_matches(ex_q, r)) begin
            return FWD_SEL_MEM;
        end else if (slot_matches(mem_q, r)) begin
            return FWD_SEL_WB;
        end
        return FWD_SEL_REG;
    endfunction

    always_comb begin
        id_slot.valid     = id_valid_i;
        id_slot.dst       = id_dst_i;
        id_slot.reg_write = id_reg_write_i;
        id_slot.mem_read  = id_mem_read_i;

        // rt is compared even for instructions that do not read it.
        hazard = id_valid_i & ex_q.valid & ex_q.mem_read & ex_q.reg_write
               & (ex_q.dst != '0)
               & ((ex_q.dst == id_rs_i) | (ex_q.dst == id_rt_i));

        stall_o   = hazard & ~flush_i;
        ex_bubble = ~(id_valid_i & ~stall_o & ~flush_i);

        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        if (enable_i) begin
            if (ex_bubble) begin
                fwd_a_sel_d = FWD_SEL_REG;
                fwd_b_sel_d = FWD_SEL_REG;
            end else begin
                fwd_a_sel_d = sel_for(id_rs_i);
                fwd_b_sel_d = sel_for(id_rt_i);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fwd_a_sel_q <= FWD_SEL_REG;
            fwd_b_sel_q <= FWD_SEL_REG;
        end else begin
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_sel_q;
    assign fwd_b_sel_o = fwd_b_sel_q;

    fwd_slot_reg u_ex_slot (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .bubble_i  (ex_bubble),
        .slot_i    (id_slot),
        .slot_o    (ex_q)
    );

    fwd_slot_reg u_mem_slot (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .bubble_i  (1'b0),
        .slot_i    (ex_q),
        .slot_o    (mem_q)
    );

    // WB is tracked for completeness; the write-first register file covers it.
    fwd_slot_reg u_wb_slot (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .bubble_i  (1'b0),
        .slot_i    (mem_q),
        .slot_o    (wb_q)
    );

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit with an instruction-history reference model.
module tb_forwarding_unit;

    logic       clock_i;
    logic       reset_n_i;
    logic       enable_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic [4:0] id_dst_i;
    logic       id_reg_write_i;
    logic       id_mem_read_i;
    logic       flush_i;
    logic       stall_o;
    logic [1:0] fwd_a_sel_o;
    logic [1:0] fwd_b_sel_o;

    forwarding_unit #(.NB_REG_ADDR(5)) dut (
        .clock_i        (clock_i),
        .reset_n_i      (reset_n_i),
        .enable_i       (enable_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_dst_i       (id_dst_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .fwd_a_sel_o    (fwd_a_sel_o),
        .fwd_b_sel_o    (fwd_b_sel_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
    } ins_t;

    // Instructions that entered EX one and two advances ago.
    ins_t prev1;
    ins_t prev2;
    int   exp_a;
    int   exp_b;
    int   n_chk;
    int   n_err;
    bit   last_stall;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input ins_t p, input int r);
        return p.v && p.rw && r != 0 && p.dst == r;
    endfunction

    // Distance to the newest earlier writer of r: 1 -> EX/MEM result, 2 -> MEM/WB data.
    function automatic int newest(input int r);
        if (writes(prev1, r)) return 2;
        if (writes(prev2, r)) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        prev1 = '{0, 0, 0, 0};
        prev2 = '{0, 0, 0, 0};
        exp_a = 0;
        exp_b = 0;
    endtask

    // Presents one ID cycle starting at a falling edge, compares, then advances the model.
    task automatic cyc(input bit v, input int rs, input int rt, input int dst,
                       input bit rw, input bit mr, input bit fl, input bit en);
        bit   exp_stall;
        bit   enters;
        ins_t nxt;
        int   na;
        int   nb;
        id_valid_i     = v;
        id_rs_i        = rs[4:0];
        id_rt_i        = rt[4:0];
        id_dst_i       = dst[4:0];
        id_reg_write_i = rw;
        id_mem_read_i  = mr;
        flush_i        = fl;
        enable_i       = en;
        #1;
        exp_stall = v && prev1.v && prev1.mr && prev1.rw && prev1.dst != 0
                    && (prev1.dst == rs || prev1.dst == rt) && !fl;
        check("stall", int'(stall_o), int'(exp_stall));
        check("sel_a", int'(fwd_a_sel_o), exp_a);
        check("sel_b", int'(fwd_b_sel_o), exp_b);
        last_stall = stall_o;
        enters = v && !exp_stall && !fl;
        nxt = enters ? '{1, dst, rw, mr} : '{0, 0, 0, 0};
        na  = enters ? newest(rs) : 0;
        nb  = enters ? newest(rt) : 0;
        @(posedge clock_i);
        if (en) begin
            prev2 = prev1;
            prev1 = nxt;
            exp_a = na;
            exp_b = nb;
        end
        @(negedge clock_i);
        check("sel_a_post", int'(fwd_a_sel_o), exp_a);
        check("sel_b_post", int'(fwd_b_sel_o), exp_b);
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_clear();
        reset_n_i = 1'b0;
        enable_i = 1'b0; id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0;
        id_dst_i = '0; id_reg_write_i = 1'b0; id_mem_read_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(negedge clock_i);
        check("reset_sel_a", int'(fwd_a_sel_o), 0);
        check("reset_sel_b", int'(fwd_b_sel_o), 0);
        check("reset_stall", int'(stall_o), 0);
        reset_n_i = 1'b1;
        @(negedge clock_i);

        // addu $3,$1,$2 ; subu $4,$3,$1
        cyc(1, 1, 2, 3, 1, 0, 0, 1);
        cyc(1, 3, 1, 4, 1, 0, 0, 1);
        check("b2b_a", int'(fwd_a_sel_o), 2);
        check("b2b_b", int'(fwd_b_sel_o), 0);
        nop(); nop();

        // distance 2: writer of $5, nop, consumer with rt=$5
        cyc(1, 0, 0, 5, 1, 0, 0, 1);
        nop();
        cyc(1, 6, 5, 9, 1, 0, 0, 1);
        check("dist2_a", int'(fwd_a_sel_o), 0);
        check("dist2_b", int'(fwd_b_sel_o), 1);
        nop(); nop();

        // double hit on $2: newest producer wins
        cyc(1, 1, 1, 2, 1, 0, 0, 1);
        cyc(1, 1, 1, 2, 1, 0, 0, 1);
        cyc(1, 2, 2, 20, 1, 0, 0, 1);
        check("dbl_a", int'(fwd_a_sel_o), 2);
        check("dbl_b", int'(fwd_b_sel_o), 2);
        nop(); nop();

        // lw $7 ; addu $8,$7,$7 : one stall, then both 01
        cyc(1, 1, 0, 7, 1, 1, 0, 1);
        cyc(1, 7, 7, 8, 1, 0, 0, 1);
        check("lu_stall1", int'(last_stall), 1);
        check("lu_bubble_a", int'(fwd_a_sel_o), 0);
        cyc(1, 7, 7, 8, 1, 0, 0, 1);
        check("lu_stall2", int'(last_stall), 0);
        check("lu_a", int'(fwd_a_sel_o), 1);
        check("lu_b", int'(fwd_b_sel_o), 1);
        cyc(1, 8, 0, 9, 1, 0, 0, 1);
        check("lu_next_stall", int'(last_stall), 0);
        check("lu_next_a", int'(fwd_a_sel_o), 2);
        nop(); nop();

        // loads and ALU writes to $zero never forward or stall
        cyc(1, 0, 0, 0, 1, 1, 0, 1);
        cyc(1, 0, 0, 16, 1, 0, 0, 1);
        check("zero_stall", int'(last_stall), 0);
        check("zero_a", int'(fwd_a_sel_o), 0);
        check("zero_b", int'(fwd_b_sel_o), 0);
        nop(); nop();

        // flush during a load-use hazard: no stall, bubble in EX
        cyc(1, 1, 0, 10, 1, 1, 0, 1);
        cyc(1, 10, 0, 11, 1, 0, 1, 1);
        check("fl_stall", int'(last_stall), 0);
        check("fl_a", int'(fwd_a_sel_o), 0);
        cyc(1, 11, 10, 17, 1, 0, 0, 1);
        check("fl_next_stall", int'(last_stall), 0);
        check("fl_next_a", int'(fwd_a_sel_o), 0);
        check("fl_next_b", int'(fwd_b_sel_o), 1);
        nop(); nop();

        // freeze for three cycles with a forwarded consumer in EX
        cyc(1, 0, 0, 12, 1, 0, 0, 1);
        cyc(1, 12, 0, 13, 1, 0, 0, 1);
        check("frz_pre_a", int'(fwd_a_sel_o), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 12, 0, 15, 1, 0, 0, 0);
            check("frz_hold_a", int'(fwd_a_sel_o), 2);
        end
        cyc(1, 12, 13, 15, 1, 0, 0, 1);
        check("frz_after_a", int'(fwd_a_sel_o), 1);
        check("frz_after_b", int'(fwd_b_sel_o), 2);
        nop(); nop();

        // reset pulse mid-sequence discards the in-flight producer
        cyc(1, 0, 0, 17, 1, 0, 0, 1);
        cyc(1, 17, 0, 14, 1, 0, 0, 1);
        check("rst_pre_a", int'(fwd_a_sel_o), 2);
        id_valid_i = 1'b0;
        flush_i    = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        check("rst_now_a", int'(fwd_a_sel_o), 0);
        check("rst_now_b", int'(fwd_b_sel_o), 0);
        check("rst_now_stall", int'(stall_o), 0);
        model_clear();
        @(negedge clock_i);
        reset_n_i = 1'b1;
        cyc(1, 14, 17, 18, 1, 0, 0, 1);
        check("rst_after_a", int'(fwd_a_sel_o), 0);
        check("rst_after_b", int'(fwd_b_sel_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
